// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_load_fetch_ctrl_if.sv
// Loader, fetch and memory-port signals of the instruction-memory controller.
interface imem_load_fetch_ctrl_if #(
    parameter int DEPTH = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic              core_run;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              instr_valid;
    logic [31:0]       instr;
    logic              fetch_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // slave is the controller's view, master the loader/core/memory side
    modport slave (
        input  load_start, load_len, load_valid, load_data,
        input  fetch_req, fetch_addr, mem_rdata,
        output load_ready, load_done, load_err, core_run,
        output fetch_gnt, instr_valid, instr, fetch_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output load_start, load_len, load_valid, load_data,
        output fetch_req, fetch_addr, mem_rdata,
        input  load_ready, load_done, load_err, core_run,
        input  fetch_gnt, instr_valid, instr, fetch_err,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_load_fetch_ctrl.sv
// Arbitrates the single instruction-memory port between the program loader
// and the core fetch stage; the core stays stalled until a load has finished.
//
// state | meaning
// IDLE  | after reset, core stalled, waiting for load_start
// LOAD  | accepting loader words into memory starting at address 0
// RUN   | core released, fetches granted with 1-cycle response
module imem_load_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] NOP_INSTR = imem_ctrl_pkg::NOP_INSTR
) (
    input logic                   clk,
    input logic                   reset,
    imem_load_fetch_ctrl_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       instr_q, instr_d;

    logic              len_ok, len_zero, fetch_legal;
    logic              mem_we_c, load_ready_c, core_run_c, fetch_gnt_c;
    logic [31:0]       mem_wdata_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rem_q       <= '0;
            mem_addr_q  <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rem_q       <= rem_d;
            mem_addr_q  <= mem_addr_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            instr_q     <= instr_d;
        end
    end

    always_comb begin
        len_ok      = (bus.load_len <= DEPTH_LEN);
        len_zero    = (bus.load_len == '0);
        fetch_legal = (bus.fetch_addr[1:0] == 2'b00) &&
                      (bus.fetch_addr[31:2] < 30'(DEPTH));

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rem_d        = rem_q;
        mem_addr_d   = mem_addr_q;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        mem_we_c     = 1'b0;
        mem_wdata_c  = '0;
        load_ready_c = 1'b0;
        core_run_c   = 1'b0;
        fetch_gnt_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    if (!len_ok) begin
                        load_err_d = 1'b1;
                    end else if (len_zero) begin
                        state_d = RUN;
                    end else begin
                        state_d  = LOAD;
                        wr_ptr_d = '0;
                        rem_d    = bus.load_len;
                    end
                end
            end
            LOAD: begin
                load_ready_c = 1'b1;
                if (bus.load_valid) begin
                    mem_we_c    = 1'b1;
                    mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
                    mem_wdata_c = bus.load_data;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    // remaining-count terminal compare marks the last word
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                core_run_c = 1'b1;
                // a reload request takes priority over any fetch this cycle
                if (bus.load_start) begin
                    if (!len_ok) begin
                        load_err_d = 1'b1;
                    end else if (!len_zero) begin
                        state_d    = LOAD;
                        wr_ptr_d   = '0;
                        rem_d      = bus.load_len;
                        core_run_c = 1'b0;
                    end
                end else if (bus.fetch_req) begin
                    fetch_gnt_c = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (fetch_legal) begin
                        mem_addr_d = bus.fetch_addr[ADDR_W+1:2];
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // instr shows the live memory data on a response and holds otherwise
        if (rsp_valid_q) begin
            instr_d = rsp_err_q ? NOP_INSTR : bus.mem_rdata;
        end else begin
            instr_d = instr_q;
        end
    end

    assign bus.load_ready  = load_ready_c;
    assign bus.load_done   = load_done_q;
    assign bus.load_err    = load_err_q;
    assign bus.core_run    = core_run_c;
    assign bus.fetch_gnt   = fetch_gnt_c;
    assign bus.instr_valid = rsp_valid_q;
    assign bus.fetch_err   = rsp_valid_q & rsp_err_q;
    assign bus.instr       = instr_d;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_d;
    assign bus.mem_wdata   = mem_wdata_c;

endmodule
